// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and the fetch-queue entry layout used by the prefetch stage.
package riscv_pkg;

   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;

   localparam logic [XLEN-1:0]    RESET_PC = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] NOP      = 32'h0000_0013;

   // One queue entry: the instruction together with the address it was fetched from.
   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Instruction addresses are always word aligned; the low two bits are dropped.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Memory read port, fetch output handshake and redirect port of the prefetch stage.
// master: the prefetcher; slave: the memory / decode environment around it.
interface instr_prefetch_queue_if;
   import riscv_pkg::*;

   logic               mem_req;
   logic [XLEN-1:0]    mem_addr;
   logic               mem_gnt;
   logic               mem_rvalid;
   logic [INSTR_W-1:0] mem_rdata;

   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [XLEN-1:0]    out_pc;

   logic               redirect_valid;
   logic [XLEN-1:0]    redirect_pc;

   modport master (
      output mem_req, mem_addr,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output out_valid, out_instr, out_pc,
      input  out_ready,
      input  redirect_valid, redirect_pc
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  out_valid, out_instr, out_pc,
      output out_ready,
      output redirect_valid, redirect_pc
   );

endinterface

// File: rtl/instr_prefetch_queue_fifo.sv
// sync_fifo: small show-ahead FIFO with synchronous flush. The head entry is read
// combinationally from the storage registers so it is visible the cycle after the push.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count     = wr_ptr_reg - rd_ptr_reg;
   assign empty     = (count == '0);
   assign full      = (count == (AW+1)'(DEPTH));
   assign do_push   = push && !full && !flush;
   assign do_pop    = pop && !empty && !flush;
   assign head_data = mem_reg[rd_ptr_reg[AW-1:0]];

   // Storage write; contents need no reset because the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
      end
   end

   // Pointer update; flush empties the queue in one cycle.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: streams sequential instruction words from memory into an in-order
// queue and presents {pc, instr} through a valid/ready handshake. A redirect flushes the
// queue, restarts fetch and drops responses still in flight.
// Optional feature macro: PREFETCH_STATS_EN adds stat_flush / stat_starve counters.
module instr_prefetch_queue
   import riscv_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter int              MAX_OUT  = 2,
   parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
   input  logic                   clk,
   input  logic                   reset,
   instr_prefetch_queue_if.master bus
`ifdef PREFETCH_STATS_EN
   ,
   output logic [31:0]            stat_flush,
   output logic [31:0]            stat_starve
`endif
);

   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] fetch_pc_reg;
   logic [XLEN-1:0] rsp_pc_reg;
   logic [OW-1:0]   outstanding_reg;
   logic [OW-1:0]   discard_reg;

   logic [CW-1:0]   q_count;
   logic            q_empty;
   logic            q_full;
   logic            issue;
   logic            grant;
   logic            push;
   logic            pop;
   logic            head_valid;
   fetch_entry_t    head;
   fetch_entry_t    push_entry;

   // Issue only while the queue can absorb every word already requested plus this one;
   // nothing is requested during reset since the memory side is reset on the same edge.
   always_comb begin
      issue = !reset && !bus.redirect_valid
              && (outstanding_reg < OW'(MAX_OUT))
              && ((32'(q_count) + 32'(outstanding_reg)) < 32'(DEPTH));
   end

   assign grant      = issue && bus.mem_gnt;
   assign head_valid = !reset && !q_empty;
   assign push       = bus.mem_rvalid && (discard_reg == '0) && !bus.redirect_valid;
   assign pop        = head_valid && bus.out_ready && !bus.redirect_valid;
   assign push_entry = '{pc: rsp_pc_reg, instr: bus.mem_rdata};

   assign bus.mem_req   = issue;
   assign bus.mem_addr  = fetch_pc_reg;
   assign bus.out_valid = head_valid;
   assign bus.out_pc    = head_valid ? head.pc    : '0;
   assign bus.out_instr = head_valid ? head.instr : '0;

   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (bus.redirect_valid),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head_data (head),
      .count     (q_count),
      .empty     (q_empty),
      .full      (q_full)
   );

   // Fetch/response address tracking, outstanding-read count and stale-response discard.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_reg    <= word_align(RESET_PC);
         rsp_pc_reg      <= word_align(RESET_PC);
         outstanding_reg <= '0;
         discard_reg     <= '0;
      end else begin
         outstanding_reg <= outstanding_reg + OW'(grant) - OW'(bus.mem_rvalid);
         if (bus.redirect_valid) begin
            fetch_pc_reg <= word_align(bus.redirect_pc);
            rsp_pc_reg   <= word_align(bus.redirect_pc);
            // A response arriving in the redirect cycle is already dropped by the flush.
            discard_reg  <= outstanding_reg - OW'(bus.mem_rvalid);
         end else begin
            if (grant) fetch_pc_reg <= fetch_pc_reg + 32'd4;
            if (bus.mem_rvalid) begin
               if (discard_reg != '0) discard_reg <= discard_reg - OW'(1);
               else                   rsp_pc_reg  <= rsp_pc_reg + 32'd4;
            end
         end
      end
   end

`ifdef PREFETCH_STATS_EN
   logic [31:0] stat_flush_reg;
   logic [31:0] stat_starve_reg;

   // Saturating redirect and starvation counters; observation only.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_flush_reg  <= '0;
         stat_starve_reg <= '0;
      end else begin
         if (bus.redirect_valid && (stat_flush_reg != '1))
            stat_flush_reg <= stat_flush_reg + 32'd1;
         if (bus.out_ready && !head_valid && (stat_starve_reg != '1))
            stat_starve_reg <= stat_starve_reg + 32'd1;
      end
   end

   assign stat_flush  = stat_flush_reg;
   assign stat_starve = stat_starve_reg;
`endif

   a_rvalid_legal: assert property (@(posedge clk) disable iff (reset)
      bus.mem_rvalid |-> (outstanding_reg != '0));
   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      push |-> !q_full);

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: in-order memory model with configurable latency, a
// scoreboard that expects consecutive word addresses from the last reset/redirect target,
// a vector table for the first streaming cycles, directed corner sequences and a random run.
// Optional feature macro: PREFETCH_STATS_EN (stat ports connected and checked).
module tb_instr_prefetch_queue;
   import riscv_pkg::*;

   localparam int DEPTH   = 4;
   localparam int MAX_OUT = 2;

   logic clk = 1'b0;
   logic reset;

   instr_prefetch_queue_if bus ();

`ifdef PREFETCH_STATS_EN
   logic [31:0] stat_flush;
   logic [31:0] stat_starve;
`endif

   instr_prefetch_queue #(
      .DEPTH    (DEPTH),
      .MAX_OUT  (MAX_OUT),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef PREFETCH_STATS_EN
      ,
      .stat_flush  (stat_flush),
      .stat_starve (stat_starve)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   typedef struct {
      bit          ready;
      bit          exp_valid;
      logic [31:0] exp_pc;
      bit          exp_req;
      logic [31:0] exp_addr;
   } vec_t;

   req_t        pending[$];
   vec_t        vecs[5];
   int          cyc;
   int          lat;
   int          last_due;
   int          checks;
   int          errors;
   int          flush_cnt;
   int          pops;
   logic [31:0] exp_pc;
   logic        s_req;
   logic        s_valid;
   logic [31:0] s_addr;
   logic [31:0] s_pc;
   logic [31:0] s_instr;
   logic        s_rvalid;

   // Memory contents: two fixed words at 0x0/0x4, a hash of the address elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0020_8193;
      if (a == 32'h4) return 32'h0011_0113;
      return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%08h required=%08h", name, act, req);
      end
   endtask

   // One clock cycle: drive inputs at negedge, sample settled outputs, then update the
   // memory model and scoreboard with what the coming rising edge will commit.
   task automatic step(input bit rst, input bit rdy, input bit gnt, input bit redir,
                       input logic [31:0] rpc);
      int d;
      @(negedge clk);
      reset              = rst;
      bus.out_ready      = rdy;
      bus.mem_gnt        = gnt;
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      if (!rst && pending.size() > 0 && pending[0].due <= cyc) begin
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = mem_word(pending[0].addr);
         void'(pending.pop_front());
      end else begin
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata  = $urandom;
      end
      #1;
      s_req    = bus.mem_req;
      s_addr   = bus.mem_addr;
      s_valid  = bus.out_valid;
      s_pc     = bus.out_pc;
      s_instr  = bus.out_instr;
      s_rvalid = bus.mem_rvalid;
      if (rst) begin
         pending.delete();
         exp_pc    = 32'h0;
         flush_cnt = 0;
         last_due  = 0;
      end else begin
         if (s_req && gnt) begin
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pending.push_back('{addr: s_addr, due: d});
            chk("outstanding_bound", 32'(pending.size() <= MAX_OUT), 32'd1);
         end
         if (redir) begin
            exp_pc = {rpc[31:2], 2'b00};
            flush_cnt++;
         end else if (s_valid && rdy) begin
            $display("pop pc=%08h instr=%08h", s_pc, s_instr);
            pops++;
            chk("pop_pc", s_pc, exp_pc);
            chk("pop_instr", s_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("rst_mem_req", 32'(s_req), 32'd0);
      chk("rst_out_valid", 32'(s_valid), 32'd0);
      chk("rst_out_pc", s_pc, 32'd0);
      chk("rst_out_instr", s_instr, 32'd0);
   endtask

   // Step with a ready consumer until the head is valid, then compare its pc.
   task automatic wait_valid(input string name, input logic [31:0] want);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         if (s_valid) begin
            seen = 1'b1;
            chk(name, s_pc, want);
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s timeout actual=no_valid required=valid", name);
      end
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0; lat = 1; last_due = 0; flush_cnt = 0; pops = 0;
      exp_pc = 32'h0;
      reset = 1'b1;
      bus.out_ready = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      bus.mem_rdata = 32'h0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;

      // Stream from reset, latency 1, always granted and ready.
      vecs[0] = '{ready: 1'b1, exp_valid: 1'b0, exp_pc: 32'h0, exp_req: 1'b1, exp_addr: 32'h0};
      vecs[1] = '{ready: 1'b1, exp_valid: 1'b0, exp_pc: 32'h0, exp_req: 1'b1, exp_addr: 32'h4};
      vecs[2] = '{ready: 1'b1, exp_valid: 1'b1, exp_pc: 32'h0, exp_req: 1'b1, exp_addr: 32'h8};
      vecs[3] = '{ready: 1'b1, exp_valid: 1'b1, exp_pc: 32'h4, exp_req: 1'b1, exp_addr: 32'hC};
      vecs[4] = '{ready: 1'b1, exp_valid: 1'b1, exp_pc: 32'h8, exp_req: 1'b1, exp_addr: 32'h10};

      do_reset();
      lat = 1;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, vecs[i].ready, 1'b1, 1'b0, 32'h0);
         chk("t1_valid", 32'(s_valid), 32'(vecs[i].exp_valid));
         chk("t1_pc", s_pc, vecs[i].exp_pc);
         chk("t1_instr", s_instr, vecs[i].exp_valid ? mem_word(vecs[i].exp_pc) : 32'h0);
         chk("t1_req", 32'(s_req), 32'(vecs[i].exp_req));
         if (vecs[i].exp_req) chk("t1_addr", s_addr, vecs[i].exp_addr);
      end

      // Backpressure: queue fills, fetch stops, head holds; then drains in order.
      do_reset();
      lat = 1;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
         if (i >= 6) begin
            chk("t2_hold_pc", s_pc, 32'h0);
            chk("t2_hold_valid", 32'(s_valid), 32'd1);
            chk("t2_no_req", 32'(s_req), 32'd0);
            chk("t2_outstanding", 32'(pending.size()), 32'd0);
         end
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
         chk("t2_drain_valid", 32'(s_valid), 32'd1);
      end
      chk("t2_drained_to", exp_pc, 32'h10);

      // Redirect with two reads in flight.
      do_reset();
      lat = 3;
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
      chk("t3_req_forced_low", 32'(s_req), 32'd0);
      chk("t3_inflight", 32'(pending.size()), 32'd2);
      wait_valid("t3_first_pc", 32'h40);

      // Redirect coinciding with a response and a pop.
      do_reset();
      lat = 2;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h80);
      chk("t4_head_valid", 32'(s_valid), 32'd1);
      chk("t4_rvalid", 32'(s_rvalid), 32'd1);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("t4_empty", 32'(s_valid), 32'd0);
      chk("t4_req", 32'(s_req), 32'd1);
      chk("t4_addr", s_addr, 32'h80);
      wait_valid("t4_first_pc", 32'h80);
      wait_valid("t4_second_pc", 32'h84);

      // Address wrap; low redirect bits ignored.
      lat = 1;
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
      wait_valid("t5_top_pc", 32'hFFFF_FFFC);
      wait_valid("t5_wrap_pc", 32'h0000_0000);
`ifdef PREFETCH_STATS_EN
      chk("stat_flush_count", stat_flush, 32'(flush_cnt));
`endif

      // Reset in the middle of a stream.
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      do_reset();
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("t6_valid_after", 32'(s_valid), 32'd0);
      chk("t6_req_after", 32'(s_req), 32'd1);
      chk("t6_addr_after", s_addr, 32'h0);
`ifdef PREFETCH_STATS_EN
      chk("t6_stat_flush", stat_flush, 32'd0);
`endif

      // Random traffic against the scoreboard.
      do_reset();
      pops = 0;
      for (int i = 0; i < 400; i++) begin
         lat = $urandom_range(1, 4);
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 9) < 7), ($urandom_range(0, 29) == 0), $urandom);
      end
      chk("rand_progress", 32'(pops > 50), 32'd1);
`ifdef PREFETCH_STATS_EN
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("rand_stat_flush", stat_flush, 32'(flush_cnt));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
